// File: rtl/network_pkg.sv
// Network-side types shared by packet-processing blocks.
package network_pkg;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [7:0]  protocol;
    } packet_s;

    localparam int PACKET_W = $bits(packet_s);

endpackage

// File: rtl/node_pkg.sv
// Node-level control types and constants for the classifier dispatcher.
package node_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DROP,
        WAIT_DONE,
        HOLD
    } dispatch_state_e;

    localparam logic [15:0] CYCLES_MAX = 16'hFFFF;
    // Latency count in the fourth cycle after issue; a classifier still ready then never dropped.
    localparam logic [15:0] NODROP_LIMIT = 16'd5;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, power-of-two depth; status flags derive from the registered count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/classifier_dispatch.sv
// Queues tuples, issues them one at a time to an external classifier and returns
// the captured rule bounds with a sequence tag and the classify latency.
module classifier_dispatch
    import network_pkg::*;
    import node_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  packet_s          in_packet,
    output logic             cls_valid,
    output packet_s          cls_packet,
    input  logic             cls_ready,
    input  packet_s          cls_first,
    input  packet_s          cls_last,
    output logic             out_valid,
    input  logic             out_ready,
    output packet_s          out_first,
    output packet_s          out_last,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      out_cycles,
    output logic             err_nodrop
);

    localparam int ENTRY_W = PACKET_W + TAG_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CYCLES_MAX) ? v : v + 16'd1;
    endfunction

    dispatch_state_e  state;
    dispatch_state_e  state_nx;

    logic [ENTRY_W-1:0] fifo_din;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    packet_s            head_pkt;
    logic [TAG_W-1:0]   head_tag;
    logic [TAG_W-1:0]   tag_cnt;
    logic [TAG_W-1:0]   issue_tag;
    logic [15:0]        lat_cnt;

    logic               load_issue;
    logic               capture;
    logic               nodrop_to;

    // The tag rides through the FIFO with its tuple so ordering is preserved by construction.
    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign fifo_din  = {tag_cnt, in_packet};
    assign head_pkt  = fifo_dout[PACKET_W-1:0];
    assign head_tag  = fifo_dout[ENTRY_W-1 -: TAG_W];
    assign out_valid = (state == HOLD);

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_nx   = state;
        cls_valid  = 1'b0;
        fifo_pop   = 1'b0;
        load_issue = 1'b0;
        capture    = 1'b0;
        nodrop_to  = 1'b0;
        unique case (state)
            IDLE: begin
                if ((fifo_count != '0) && cls_ready) begin
                    state_nx   = ISSUE;
                    load_issue = 1'b1;
                end
            end
            // The pulse is gated by cls_ready so the classifier never sees valid while busy.
            ISSUE: begin
                if (fifo_empty) begin
                    state_nx = IDLE;
                end else if (cls_ready) begin
                    cls_valid = 1'b1;
                    fifo_pop  = 1'b1;
                    state_nx  = WAIT_DROP;
                end
            end
            WAIT_DROP: begin
                if (!cls_ready) begin
                    state_nx = WAIT_DONE;
                end else if (lat_cnt >= NODROP_LIMIT) begin
                    state_nx  = WAIT_DONE;
                    nodrop_to = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (cls_ready) begin
                    capture  = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // lat_cnt reads 1 during the issue cycle (implicitly) and 2 on the cycle after.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tag_cnt    <= '0;
            cls_packet <= '0;
            issue_tag  <= '0;
            lat_cnt    <= '0;
            out_first  <= '0;
            out_last   <= '0;
            out_tag    <= '0;
            out_cycles <= '0;
            err_nodrop <= 1'b0;
        end else begin
            state <= state_nx;
            if (fifo_push) begin
                tag_cnt <= tag_cnt + TAG_W'(1);
            end
            if (load_issue) begin
                cls_packet <= head_pkt;
                issue_tag  <= head_tag;
            end
            if (cls_valid) begin
                lat_cnt <= 16'd2;
            end else if ((state == WAIT_DROP) || (state == WAIT_DONE)) begin
                lat_cnt <= sat_inc(lat_cnt);
            end
            if (nodrop_to) begin
                err_nodrop <= 1'b1;
            end
            if (capture) begin
                out_first  <= cls_first;
                out_last   <= cls_last;
                out_tag    <= issue_tag;
                out_cycles <= lat_cnt;
            end
        end
    end

endmodule

// File: tb/tb_classifier_dispatch.sv
// Bench for classifier_dispatch: table vectors, corner sequences and randomized traffic
// against a behavioural classifier model and a result scoreboard.
module tb_classifier_dispatch;
    import network_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    packet_s     in_packet = '0;
    logic        cls_valid;
    packet_s     cls_packet;
    logic        cls_ready;
    packet_s     cls_first;
    packet_s     cls_last;
    logic        out_valid;
    logic        out_ready = 1'b1;
    packet_s     out_first;
    packet_s     out_last;
    logic [7:0]  out_tag;
    logic [15:0] out_cycles;
    logic        err_nodrop;

    classifier_dispatch #(.FIFO_DEPTH(4), .TAG_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_packet  (in_packet),
        .cls_valid  (cls_valid),
        .cls_packet (cls_packet),
        .cls_ready  (cls_ready),
        .cls_first  (cls_first),
        .cls_last   (cls_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_first  (out_first),
        .out_last   (out_last),
        .out_tag    (out_tag),
        .out_cycles (out_cycles),
        .err_nodrop (err_nodrop)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        packet_s    p;
        logic [7:0] tag;
    } exp_t;

    exp_t        exp_q[$];
    packet_s     issue_q[$];
    logic [15:0] cyc_q[$];
    int          acc_idx = 0;
    int          outs = 0;

    int   lat_cfg = 7;
    logic nodrop_cfg = 1'b0;
    logic cls_hold = 1'b0;
    logic model_busy = 1'b0;

    function automatic packet_s mk_pkt(input logic [31:0] s, input logic [31:0] d,
                                       input logic [15:0] sp, input logic [15:0] dp,
                                       input logic [7:0] pr);
        packet_s p;
        p.src_ip = s; p.dst_ip = d; p.src_port = sp; p.dst_port = dp; p.protocol = pr;
        return p;
    endfunction

    function automatic packet_s rand_pkt();
        return mk_pkt($urandom, $urandom, 16'($urandom), 16'($urandom), 8'($urandom));
    endfunction

    // Classifier rule: a prefix range around the tuple.
    function automatic packet_s rule_first(input packet_s p);
        return mk_pkt(p.src_ip & 32'hFFFF_FF00, p.dst_ip & 32'hFFFF_0000, 16'h0000, p.dst_port, p.protocol);
    endfunction

    function automatic packet_s rule_last(input packet_s p);
        return mk_pkt(p.src_ip | 32'h0000_00FF, p.dst_ip | 32'h0000_FFFF, 16'hFFFF, p.dst_port, p.protocol);
    endfunction

    function automatic logic [15:0] exp_cycles(input int lat, input logic nd);
        if (nd) return 16'd6;
        return (lat > 65535) ? 16'hFFFF : 16'(lat);
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Classifier model: after a pulse, drop ready for lat-2 cycles, then present the rule.
    initial begin : classifier_model
        logic    issue;
        packet_s p;
        int      lat;
        logic    nd;
        int      n;
        cls_ready = 1'b1;
        cls_first = '0;
        cls_last  = '0;
        forever begin
            @(negedge clk);
            issue = cls_valid && !reset;
            p     = cls_packet;
            lat   = lat_cfg;
            nd    = nodrop_cfg;
            @(posedge clk); #1;
            if (issue) begin
                model_busy = 1'b1;
                cls_first  = rule_first(p);
                cls_last   = rule_last(p);
                cls_ready  = nd;
                n = nd ? 4 : lat - 2;
                for (int k = 0; k < n; k++) begin
                    @(negedge clk);
                    if (reset) break;
                    @(posedge clk); #1;
                end
                cls_ready  = 1'b1;
                model_busy = 1'b0;
            end else begin
                cls_ready = !cls_hold;
            end
        end
    end

    // Scoreboard: ingress order defines tags; results must come back in that order.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            issue_q.delete();
            cyc_q.delete();
            acc_idx = 0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back('{p: in_packet, tag: acc_idx[7:0]});
                issue_q.push_back(in_packet);
                acc_idx++;
            end
            if (cls_valid) begin
                check("cls_ready_at_issue", cls_ready, 1'b1);
                check("one_in_flight", model_busy, 1'b0);
                check("issue_pending", issue_q.size() != 0, 1'b1);
                if (issue_q.size() != 0) check("cls_packet_order", cls_packet, issue_q.pop_front());
                cyc_q.push_back(exp_cycles(lat_cfg, nodrop_cfg));
            end
            if (out_valid && out_ready) begin
                outs++;
                check("out_pending", (exp_q.size() != 0) && (cyc_q.size() != 0), 1'b1);
                if ((exp_q.size() != 0) && (cyc_q.size() != 0)) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_tag", out_tag, e.tag);
                    check("out_first", out_first, rule_first(e.p));
                    check("out_last", out_last, rule_last(e.p));
                    check("out_cycles", out_cycles, cyc_q.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
    endtask

    task automatic push_pkt(input packet_s p);
        int n;
        n = 0;
        in_valid  = 1'b1;
        in_packet = p;
        @(negedge clk);
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("push_accepted", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_seen", out_valid, 1'b1);
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        check("drained", exp_q.size() == 0, 1'b1);
    endtask

    typedef struct {
        packet_s     pkt;
        int          lat;
        logic [15:0] exp_cyc;
        logic [7:0]  exp_tag;
    } vec_t;

    vec_t vecs[4];
    logic rand_done;
    int   accepted;
    int   outs0;

    initial begin
        vecs[0] = '{pkt: mk_pkt(32'h0A00_0001, 32'h0A00_0002, 16'd80,   16'd443, 8'd6),  lat: 7,  exp_cyc: 16'd7,  exp_tag: 8'd0};
        vecs[1] = '{pkt: mk_pkt(32'hC0A8_0105, 32'h0808_0808, 16'd5353, 16'd53,  8'd17), lat: 3,  exp_cyc: 16'd3,  exp_tag: 8'd1};
        vecs[2] = '{pkt: mk_pkt(32'hFFFF_FFFF, 32'h0000_0000, 16'hFFFF, 16'd0,   8'd1),  lat: 12, exp_cyc: 16'd12, exp_tag: 8'd2};
        vecs[3] = '{pkt: mk_pkt(32'h7F00_0001, 32'h7F00_0001, 16'd1,    16'd2,   8'd47), lat: 4,  exp_cyc: 16'd4,  exp_tag: 8'd3};

        do_reset();
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_cls_valid", cls_valid, 1'b0);
        check("rst_cls_packet", cls_packet, '0);
        check("rst_out_tag", out_tag, 8'd0);
        check("rst_out_cycles", out_cycles, 16'd0);
        check("rst_out_first", out_first, '0);
        check("rst_err_nodrop", err_nodrop, 1'b0);
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            lat_cfg = vecs[i].lat;
            push_pkt(vecs[i].pkt);
            wait_out(200);
            check("vec_tag", out_tag, vecs[i].exp_tag);
            check("vec_cycles", out_cycles, vecs[i].exp_cyc);
            check("vec_first", out_first, rule_first(vecs[i].pkt));
            check("vec_last", out_last, rule_last(vecs[i].pkt));
            @(posedge clk); #1;
        end
        wait_drain(200);

        // Burst into a stalled classifier: four accepts fill the FIFO.
        cls_hold = 1'b1;
        do_reset();
        outs0 = outs;
        lat_cfg = 8;
        for (int i = 0; i < 4; i++) push_pkt(rand_pkt());
        in_valid  = 1'b1;
        in_packet = rand_pkt();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("burst_full_in_ready", in_ready, 1'b0);
            check("burst_no_issue", cls_valid, 1'b0);
            @(posedge clk); #1;
        end
        cls_hold = 1'b0;
        push_pkt(in_packet);
        push_pkt(rand_pkt());
        wait_drain(1000);
        check("burst_out_count", outs - outs0, 6);

        // Long HOLD: no issue, stable outputs, exactly one slot refilled.
        do_reset();
        out_ready = 1'b0;
        lat_cfg = 5;
        for (int i = 0; i < 4; i++) push_pkt(rand_pkt());
        wait_out(200);
        @(posedge clk); #1;
        accepted  = 0;
        in_valid  = 1'b1;
        in_packet = rand_pkt();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_out_valid", out_valid, 1'b1);
            check("hold_no_issue", cls_valid, 1'b0);
            check("hold_tag", out_tag, exp_q[0].tag);
            check("hold_first", out_first, rule_first(exp_q[0].p));
            check("hold_cycles", out_cycles, cyc_q[0]);
            if (in_valid && in_ready) accepted++;
            @(posedge clk); #1;
            if (accepted != 0) in_valid = 1'b0;
        end
        @(negedge clk);
        check("hold_accepts", accepted, 1);
        check("hold_full", in_ready, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain(1000);

        // Reset while waiting on the classifier with two tuples still queued.
        do_reset();
        lat_cfg = 30;
        for (int i = 0; i < 3; i++) push_pkt(rand_pkt());
        repeat (8) begin @(posedge clk); #1; end
        check("midrst_queued", exp_q.size(), 3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        lat_cfg = 4;
        push_pkt(rand_pkt());
        wait_out(200);
        check("midrst_tag", out_tag, 8'd0);
        @(posedge clk); #1;
        wait_drain(200);

        // Classifier that never drops ready.
        do_reset();
        nodrop_cfg = 1'b1;
        @(negedge clk);
        check("nodrop_err_clear", err_nodrop, 1'b0);
        @(posedge clk); #1;
        push_pkt(rand_pkt());
        wait_out(200);
        check("nodrop_err_set", err_nodrop, 1'b1);
        check("nodrop_cycles", out_cycles, 16'd6);
        @(posedge clk); #1;
        wait_drain(200);
        nodrop_cfg = 1'b0;

        // Randomized traffic with random backpressure.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    lat_cfg = $urandom_range(3, 9);
                    push_pkt(rand_pkt());
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        wait_drain(2000);

        // Latency beyond the 16-bit counter range.
        do_reset();
        lat_cfg = 70000;
        push_pkt(rand_pkt());
        wait_out(80000);
        check("sat_cycles", out_cycles, 16'hFFFF);
        @(posedge clk); #1;
        wait_drain(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
